// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared CPU fetch definitions: FSM encoding, fetch defaults and PC range check.
package inst_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam int unsigned ROM_WORDS_DEF = 20;

  // A PC is fetchable only if word aligned and inside the populated ROM words.
  function automatic logic pc_bad(input logic [31:0] pc, input int unsigned words);
    return (pc[1:0] != 2'b00) || (32'(pc[6:2]) >= words) || (pc[31:7] != '0);
  endfunction

endpackage

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: PC sequencing, single output register with
// decode handshake, redirect flush and fault detection against an async ROM.
module inst_fetch_ctrl
  import inst_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter int unsigned ROM_WORDS = ROM_WORDS_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  output logic [4:0]  rom_addr,
  input  logic [31:0] rom_inst,
  input  logic        jbr_taken,
  input  logic [31:0] jbr_target,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        fetch_fault,
  output logic [31:0] inst_cnt
);

  fetch_state_e r_state, w_state_nxt;
  logic [31:0]  r_pc, w_pc_nxt;
  logic         r_vld, w_vld_nxt;
  logic [31:0]  r_if_pc, w_if_pc_nxt;
  logic [31:0]  r_if_inst, w_if_inst_nxt;
  logic [31:0]  r_cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= IDLE;
      r_pc      <= RESET_PC;
      r_vld     <= 1'b0;
      r_if_pc   <= '0;
      r_if_inst <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_vld     <= w_vld_nxt;
      r_if_pc   <= w_if_pc_nxt;
      r_if_inst <= w_if_inst_nxt;
    end
  end

  // Redirect beats fault check, which beats load/hold.
  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_vld_nxt     = r_vld;
    w_if_pc_nxt   = r_if_pc;
    w_if_inst_nxt = r_if_inst;
    case (r_state)
      IDLE: begin
        w_vld_nxt   = 1'b0;
        w_state_nxt = RUN;
      end
      RUN: begin
        if (jbr_taken) begin
          w_pc_nxt  = jbr_target;
          w_vld_nxt = 1'b0;
        end else if (pc_bad(r_pc, ROM_WORDS)) begin
          w_vld_nxt   = 1'b0;
          w_state_nxt = FAULT;
        end else if (!r_vld || if_ready) begin
          w_if_pc_nxt   = r_pc;
          w_if_inst_nxt = rom_inst;
          w_vld_nxt     = 1'b1;
          w_pc_nxt      = r_pc + 32'd4;
        end
      end
      FAULT: begin
        w_vld_nxt = 1'b0;
        if (jbr_taken) begin
          w_pc_nxt    = jbr_target;
          w_state_nxt = RUN;
        end
      end
      default: begin
        w_vld_nxt   = 1'b0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      r_cnt <= '0;
    else if (r_vld && if_ready)
      r_cnt <= r_cnt + 32'd1;
  end

  assign rom_addr    = r_pc[6:2];
  assign if_valid    = r_vld;
  assign if_pc       = r_if_pc;
  assign if_inst     = r_if_inst;
  assign fetch_fault = (r_state == FAULT);
  assign inst_cnt    = r_cnt;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl with a small behavioural ROM.
module tb_inst_fetch_ctrl;

  logic        clk;
  logic        resetn;
  logic [4:0]  rom_addr;
  logic [31:0] rom_inst;
  logic        jbr_taken;
  logic [31:0] jbr_target;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        fetch_fault;
  logic [31:0] inst_cnt;

  logic [31:0] rom [0:31];
  int checks;
  int failures;

  inst_fetch_ctrl #(.RESET_PC(32'h0000_0000), .ROM_WORDS(20)) dut (
    .clk(clk), .resetn(resetn), .rom_addr(rom_addr), .rom_inst(rom_inst),
    .jbr_taken(jbr_taken), .jbr_target(jbr_target), .if_valid(if_valid),
    .if_ready(if_ready), .if_pc(if_pc), .if_inst(if_inst),
    .fetch_fault(fetch_fault), .inst_cnt(inst_cnt)
  );

  assign rom_inst = rom[rom_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] pc,
                         input logic [31:0] inst, input logic [31:0] cnt, input logic flt);
    chk({tag, ".valid"}, 32'(if_valid), 32'(v));
    if (v) begin
      chk({tag, ".pc"}, if_pc, pc);
      chk({tag, ".inst"}, if_inst, inst);
    end
    chk({tag, ".cnt"}, inst_cnt, cnt);
    chk({tag, ".fault"}, 32'(fetch_fault), 32'(flt));
  endtask

  task automatic redirect(input logic [31:0] tgt);
    jbr_taken  = 1'b1;
    jbr_target = tgt;
    tick();
    jbr_taken  = 1'b0;
    jbr_target = '0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    for (int i = 0; i < 32; i++) rom[i] = 32'h1000_0000 + 32'(i);
    rom[0]  = 32'h2401000A;
    rom[1]  = 32'h00011082;
    rom[2]  = 32'h00411821;
    rom[4]  = 32'h00822823;
    rom[5]  = 32'hAC250016;
    rom[17] = 32'hAC040010;
    rom[18] = 32'h3C0C000C;
    rom[19] = 32'h08000000;

    resetn = 1'b0; if_ready = 1'b1; jbr_taken = 1'b0; jbr_target = '0;
    #2;
    chk("rst.valid", 32'(if_valid), 32'd0);
    chk("rst.pc", if_pc, 32'd0);
    chk("rst.inst", if_inst, 32'd0);
    chk("rst.fault", 32'(fetch_fault), 32'd0);
    chk("rst.cnt", inst_cnt, 32'd0);
    chk("rst.rom_addr", 32'(rom_addr), 32'd0);
    tick();
    resetn = 1'b1;

    // Streaming with decode always ready
    tick(); chk_out("bubble", 1'b0, 32'h0, 32'h0, 32'd0, 1'b0);
    tick(); chk_out("f0", 1'b1, 32'h00, 32'h2401000A, 32'd0, 1'b0);
    tick(); chk_out("f1", 1'b1, 32'h04, 32'h00011082, 32'd1, 1'b0);
    tick(); chk_out("f2", 1'b1, 32'h08, 32'h00411821, 32'd2, 1'b0);
    tick(); chk_out("f3", 1'b1, 32'h0C, 32'h10000003, 32'd3, 1'b0);
    tick(); chk_out("f4", 1'b1, 32'h10, 32'h00822823, 32'd4, 1'b0);

    // Decode stall holds the output register and pc
    if_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("hold", 1'b1, 32'h10, 32'h00822823, 32'd4, 1'b0);
      chk("hold.rom_addr", 32'(rom_addr), 32'd5);
    end
    if_ready = 1'b1;
    tick(); chk_out("f5", 1'b1, 32'h14, 32'hAC250016, 32'd5, 1'b0);

    // Redirect flushes even an accepted instruction (still counted)
    redirect(32'h44);
    chk_out("flush44", 1'b0, 32'h0, 32'h0, 32'd6, 1'b0);
    tick(); chk_out("f44", 1'b1, 32'h44, 32'hAC040010, 32'd6, 1'b0);
    tick(); chk_out("f48", 1'b1, 32'h48, 32'h3C0C000C, 32'd7, 1'b0);
    tick(); chk_out("f4c", 1'b1, 32'h4C, 32'h08000000, 32'd8, 1'b0);
    redirect(32'h00);
    chk_out("flush00", 1'b0, 32'h0, 32'h0, 32'd9, 1'b0);
    tick(); chk_out("wrap0", 1'b1, 32'h00, 32'h2401000A, 32'd9, 1'b0);

    // Out-of-range and misaligned targets fault
    redirect(32'h50);
    chk_out("r50", 1'b0, 32'h0, 32'h0, 32'd10, 1'b0);
    tick(); chk_out("flt50", 1'b0, 32'h0, 32'h0, 32'd10, 1'b1);
    tick(); chk_out("flt50b", 1'b0, 32'h0, 32'h0, 32'd10, 1'b1);
    chk("flt50.rom_addr", 32'(rom_addr), 32'd20);
    redirect(32'h02);
    chk_out("r02", 1'b0, 32'h0, 32'h0, 32'd10, 1'b0);
    tick(); chk_out("flt02", 1'b0, 32'h0, 32'h0, 32'd10, 1'b1);
    redirect(32'h00);
    chk_out("clr", 1'b0, 32'h0, 32'h0, 32'd10, 1'b0);
    tick(); chk_out("res0", 1'b1, 32'h00, 32'h2401000A, 32'd10, 1'b0);
    tick(); chk_out("res1", 1'b1, 32'h04, 32'h00011082, 32'd11, 1'b0);

    // Asynchronous reset mid-cycle
    #2 resetn = 1'b0;
    #1;
    chk("arst.valid", 32'(if_valid), 32'd0);
    chk("arst.pc", if_pc, 32'd0);
    chk("arst.inst", if_inst, 32'd0);
    chk("arst.cnt", inst_cnt, 32'd0);
    chk("arst.fault", 32'(fetch_fault), 32'd0);
    chk("arst.rom_addr", 32'(rom_addr), 32'd0);
    tick();
    resetn = 1'b1;
    tick(); chk_out("rb", 1'b0, 32'h0, 32'h0, 32'd0, 1'b0);
    tick(); chk_out("rf0", 1'b1, 32'h00, 32'h2401000A, 32'd0, 1'b0);

    // High PC bits set with an in-range word index still faults
    redirect(32'h80);
    chk_out("r80", 1'b0, 32'h0, 32'h0, 32'd1, 1'b0);
    tick(); chk_out("flt80", 1'b0, 32'h0, 32'h0, 32'd1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
